// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: bridges the dcache 256-bit line port to a 64-bit, 4-beat
// burst memory. A line read assembles four returned beats. A line write
// serialises a buffered copy of the evicted line. The cache sees a one-cycle
// line_resp when the burst finishes.
// Optional build macro CACHELINE_ADAPTOR_PERF_EN adds completed-line counters
// on rd_lines/wr_lines. Without the macro both outputs are tied to zero.
module cacheline_adaptor #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_WIDTH = 256,
  parameter int unsigned BEAT_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  line_read,
  input  logic                  line_write,
  input  logic [ADDR_WIDTH-1:0] line_addr,
  input  logic [LINE_WIDTH-1:0] line_wdata,
  output logic [LINE_WIDTH-1:0] line_rdata,
  output logic                  line_resp,
  output logic                  burst_read,
  output logic                  burst_write,
  output logic [ADDR_WIDTH-1:0] burst_addr,
  output logic [BEAT_WIDTH-1:0] burst_wdata,
  input  logic [BEAT_WIDTH-1:0] burst_rdata,
  input  logic                  burst_resp,
  output logic [31:0]           rd_lines,
  output logic [31:0]           wr_lines
);

  localparam int unsigned BEATS      = LINE_WIDTH / BEAT_WIDTH;
  localparam int unsigned BEAT_BITS  = $clog2(BEATS);
  localparam int unsigned LINE_BYTES = LINE_WIDTH / 8;
  localparam logic [BEAT_BITS-1:0]  LAST_BEAT  = BEAT_BITS'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(LINE_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic [BEAT_BITS-1:0]  beat_q, beat_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wbuf_q, wbuf_d;
  logic [LINE_WIDTH-1:0] rdata_q, rdata_d;
  logic [31:0]           beat_lsb;

  assign beat_lsb   = 32'(beat_q) * BEAT_WIDTH;
  assign line_rdata = rdata_q;

  // State, beat counter and line/address buffers; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      addr_q  <= '0;
      wbuf_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      wbuf_q  <= wbuf_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state and burst/line outputs; requests are only sampled in IDLE.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    addr_d      = addr_q;
    wbuf_d      = wbuf_q;
    rdata_d     = rdata_q;
    burst_read  = 1'b0;
    burst_write = 1'b0;
    burst_addr  = '0;
    burst_wdata = '0;
    line_resp   = 1'b0;
    case (state_q)
      IDLE: begin
        if (line_read) begin
          addr_d  = line_addr & ALIGN_MASK;
          beat_d  = '0;
          state_d = READ;
        end else if (line_write) begin
          addr_d  = line_addr & ALIGN_MASK;
          wbuf_d  = line_wdata;
          beat_d  = '0;
          state_d = WRITE;
        end
      end
      READ: begin
        burst_read = 1'b1;
        burst_addr = addr_q;
        if (burst_resp) begin
          rdata_d[beat_lsb +: BEAT_WIDTH] = burst_rdata;
          beat_d = beat_q + BEAT_BITS'(1);
          if (beat_q == LAST_BEAT) state_d = DONE;
        end
      end
      WRITE: begin
        burst_write = 1'b1;
        burst_addr  = addr_q;
        burst_wdata = wbuf_q[beat_lsb +: BEAT_WIDTH];
        if (burst_resp) begin
          beat_d = beat_q + BEAT_BITS'(1);
          if (beat_q == LAST_BEAT) state_d = DONE;
        end
      end
      DONE: begin
        line_resp = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef CACHELINE_ADAPTOR_PERF_EN
  // DONE is shared by both directions, so remember which kind of burst is in flight.
  logic        op_rd_q, op_rd_d;
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;

  // Count each completed line by direction; counters wrap naturally.
  always_comb begin
    op_rd_d  = op_rd_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (state_q == IDLE && (line_read || line_write)) op_rd_d = line_read;
    if (state_q == DONE) begin
      if (op_rd_q) rd_cnt_d = rd_cnt_q + 32'd1;
      else         wr_cnt_d = wr_cnt_q + 32'd1;
    end
  end

  // Performance counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      op_rd_q  <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      op_rd_q  <= op_rd_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_lines = rd_cnt_q;
  assign wr_lines = wr_cnt_q;
`else
  assign rd_lines = '0;
  assign wr_lines = '0;
`endif

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor. The cache and memory sides are
// modelled in terms of transactions: beat lists, stall counts and expected
// latencies worked out from the burst protocol.
module tb_cacheline_adaptor;

`ifdef CACHELINE_ADAPTOR_PERF_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         line_read = 1'b0;
  logic         line_write = 1'b0;
  logic [31:0]  line_addr = '0;
  logic [255:0] line_wdata = '0;
  logic [255:0] line_rdata;
  logic         line_resp;
  logic         burst_read;
  logic         burst_write;
  logic [31:0]  burst_addr;
  logic [63:0]  burst_wdata;
  logic [63:0]  burst_rdata = '0;
  logic         burst_resp = 1'b0;
  logic [31:0]  rd_lines;
  logic [31:0]  wr_lines;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int rd_done = 0;
  int wr_done = 0;
  logic [255:0] last_line = '0;

  cacheline_adaptor #(
    .ADDR_WIDTH(32),
    .LINE_WIDTH(256),
    .BEAT_WIDTH(64)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .line_read  (line_read),
    .line_write (line_write),
    .line_addr  (line_addr),
    .line_wdata (line_wdata),
    .line_rdata (line_rdata),
    .line_resp  (line_resp),
    .burst_read (burst_read),
    .burst_write(burst_write),
    .burst_addr (burst_addr),
    .burst_wdata(burst_wdata),
    .burst_rdata(burst_rdata),
    .burst_resp (burst_resp),
    .rd_lines   (rd_lines),
    .wr_lines   (wr_lines)
  );

  always #5 clk = ~clk;

  // Posedge count; read only at negedges.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // One line transaction seen from the cache. Starts at a negedge with the
  // adaptor idle (or in DONE when from_done=1) and ends at the negedge of the
  // line_resp cycle, dropping the request that was served.
  task automatic xfer(input bit rd, input bit wr, input logic [31:0] addr,
                      input logic [255:0] wd, input int stall, input bit from_done,
                      input bit pattern, output logic [255:0] wd_after);
    int c0, b, w, guard;
    bit op_rd;
    logic [255:0] exp_line, mid;
    logic [63:0] beat;
    logic [31:0] exp_addr;
    op_rd = rd;
    c0 = cyc;
    b = 0; w = 0; guard = 0;
    exp_line = last_line;
    exp_addr = {addr[31:5], 5'b0};
    line_read = rd;
    line_write = wr;
    line_addr = addr;
    line_wdata = wd;
    if (from_done) begin
      burst_resp = 1'b1;
      burst_rdata = rand64();
      tick();
      check("idle_gap_read", burst_read, 0);
      check("idle_gap_write", burst_write, 0);
      check("idle_gap_resp", line_resp, 0);
    end
    tick();
    mid = rand256();
    line_wdata = mid;
    while (b < 4 && guard < 64) begin
      check(op_rd ? "burst_read_high" : "burst_write_high", op_rd ? burst_read : burst_write, 1);
      check("burst_other_low", op_rd ? burst_write : burst_read, 0);
      check("burst_addr", burst_addr, exp_addr);
      check("resp_low_mid_burst", line_resp, 0);
      if (!op_rd) check("burst_wdata", burst_wdata, wd[64*b +: 64]);
      if (w == stall) begin
        beat = pattern ? {16{4'(b + 1)}} : rand64();
        if (op_rd) exp_line[64*b +: 64] = beat;
        burst_rdata = beat;
        burst_resp = 1'b1;
        b++;
        w = 0;
      end else begin
        burst_resp = 1'b0;
        burst_rdata = rand64();
        w++;
      end
      tick();
      guard++;
    end
    burst_resp = 1'b0;
    check("beats_done", b, 4);
    check("line_resp", line_resp, 1);
    check("resp_cycle", cyc - c0, 5 + 4 * stall + int'(from_done));
    check("done_read_low", burst_read, 0);
    check("done_write_low", burst_write, 0);
    if (op_rd) begin
      last_line = exp_line;
      rd_done++;
    end else begin
      wr_done++;
    end
    check("line_rdata", line_rdata, last_line);
    if (op_rd) line_read = 1'b0;
    else line_write = 1'b0;
    wd_after = mid;
  endtask

  initial begin
    logic [255:0] nxt;
    logic [255:0] dummy;
    bit bb;

    // Reset values
    rst = 1'b0;
    repeat (3) tick();
    check("rst_burst_read", burst_read, 0);
    check("rst_burst_write", burst_write, 0);
    check("rst_line_resp", line_resp, 0);
    check("rst_burst_addr", burst_addr, 0);
    check("rst_burst_wdata", burst_wdata, 0);
    check("rst_line_rdata", line_rdata, 0);
    check("rst_rd_lines", rd_lines, 0);
    check("rst_wr_lines", wr_lines, 0);
    rst = 1'b1;
    tick();

    // Zero-wait read with fixed beat pattern
    xfer(1, 0, 32'h0000_1234, rand256(), 0, 0, 1, dummy);
    check("pattern_line", line_rdata,
          256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);
    tick(); tick();
    check("rdata_hold", line_rdata, last_line);

    // Write with two idle cycles before each beat
    xfer(0, 1, $urandom, rand256(), 2, 0, 0, dummy);
    tick(); tick();
    check("rdata_hold_after_write", line_rdata, last_line);

    // Simultaneous request: read first, then the held write with its own data
    xfer(1, 1, $urandom, rand256(), $urandom_range(0, 1), 0, 0, nxt);
    xfer(0, 1, $urandom, nxt, $urandom_range(0, 1), 1, 0, dummy);
    tick(); tick();

    // Dirty miss: write-back then read fill right after line_resp
    xfer(0, 1, $urandom, rand256(), $urandom_range(0, 2), 0, 0, dummy);
    xfer(1, 0, $urandom, rand256(), $urandom_range(0, 2), 1, 0, dummy);
    tick(); tick();
    check("rd_lines_a", rd_lines, PERF != 0 ? rd_done : 0);
    check("wr_lines_a", wr_lines, PERF != 0 ? wr_done : 0);

    // Reset after the second read beat
    line_read = 1'b1;
    line_addr = $urandom;
    tick();
    check("pre_rst_burst_read", burst_read, 1);
    burst_resp = 1'b1;
    burst_rdata = rand64();
    tick();
    burst_rdata = rand64();
    tick();
    rst = 1'b0;
    burst_resp = 1'b0;
    line_read = 1'b0;
    tick();
    check("midrst_burst_read", burst_read, 0);
    check("midrst_line_resp", line_resp, 0);
    check("midrst_burst_addr", burst_addr, 0);
    check("midrst_line_rdata", line_rdata, 0);
    check("midrst_rd_lines", rd_lines, 0);
    check("midrst_wr_lines", wr_lines, 0);
    rd_done = 0;
    wr_done = 0;
    last_line = '0;
    rst = 1'b1;
    repeat (3) begin
      tick();
      check("post_rst_resp", line_resp, 0);
      check("post_rst_burst_read", burst_read, 0);
    end

    // Three reads and two writes with random spacing and stalls
    for (int i = 0; i < 5; i++) begin
      bb = (i > 0) && ($urandom_range(0, 1) == 1);
      if (i > 0 && !bb) tick();
      xfer(i % 2 == 0, i % 2 == 1, $urandom, rand256(), $urandom_range(0, 2), bb, 0, dummy);
    end
    tick(); tick();
    check("final_resp_low", line_resp, 0);
    check("final_rdata_hold", line_rdata, last_line);
    check("rd_lines_final", rd_lines, PERF != 0 ? 3 : 0);
    check("wr_lines_final", wr_lines, PERF != 0 ? 2 : 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cacheline_adaptor.md
Name: cacheline_adaptor

Overview:
- Sits directly downstream of the dcache controller, between its 256-bit line port (pmem_read/pmem_write/pmem_resp) and the 64-bit burst physical memory.
- Converts one line read or write into a 4-beat burst.
- Reads: assembles the returned beats into one line.
- Writes: serialises the dirty line being evicted.
- Line side returns a single-cycle response when the burst completes.

Parameters:
- ADDR_WIDTH, 32, byte address width on both sides.
- LINE_WIDTH, 256, cache line width in bits.
- BEAT_WIDTH, 64, burst beat width.
- BEATS = LINE_WIDTH/BEAT_WIDTH (4) is derived, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-low: adaptor resets on any rising clk edge with rst==0.
- line_read  in  1  line read request from the cache; held until line_resp.
- line_write  in  1  line write-back request from the cache; held until line_resp.
- line_addr  in  ADDR_WIDTH  line address; bits [4:0] ignored.
- line_wdata  in  LINE_WIDTH  write-back line data.
- line_rdata  out  LINE_WIDTH  assembled read line.
- line_resp  out  1  one-cycle completion pulse.
- burst_read  out  1  burst read request.
- burst_write  out  1  burst write request.
- burst_addr  out  ADDR_WIDTH  aligned burst address, {line_addr[31:5],5'b0}.
- burst_wdata  out  BEAT_WIDTH  current write beat.
- burst_rdata  in  BEAT_WIDTH  read beat from memory.
- burst_resp  in  1  beat-accept/beat-valid strobe from memory.
- rd_lines  out  32  completed read bursts (see Optional Feature).
- wr_lines  out  32  completed write bursts (see Optional Feature).

Behaviour:
- Reset values:
  - State IDLE, beat counter 0.
  - line_resp, burst_read, burst_write all 0.
  - burst_addr, burst_wdata, line_rdata all 0.
  - rd_lines, wr_lines both 0.
- States:
  - IDLE: burst outputs low. If line_read==1, latch line_addr (low 5 bits forced 0), clear beat counter, go to READ. Else if line_write==1, latch line_addr and the full line_wdata into a write buffer, go to WRITE. line_read wins if both are set; the write is serviced after the next IDLE.
  - READ: burst_read=1, burst_addr=latched address. On each burst_resp==1, store burst_rdata into line_rdata bits [64*beat+63 : 64*beat] and increment beat. Beat 0 is the low 64 bits. On the beat==3 strobe, go to DONE.
  - WRITE: burst_write=1, burst_wdata=wbuf[64*beat+63 : 64*beat] combinationally from the registered beat. Advance beat on burst_resp. On the beat==3 strobe, go to DONE.
  - DONE: line_resp=1 for exactly one cycle, burst outputs low, then go to IDLE.
- Timing and handshake:
  - burst_read/burst_write stay continuously high from the cycle after acceptance through the cycle of the 4th burst_resp, and drop the next cycle.
  - Minimum latency, request seen in IDLE at cycle 0 with burst_resp high every cycle: burst request at cycles 1–4, line_resp at cycle 5.
  - line_rdata holds its value from DONE until the next READ writes beat 0. Line data is not cleared between requests.
  - burst_resp in IDLE or DONE is ignored.
  - Request inputs are sampled only in IDLE; changes mid-burst are ignored.
  - The cache drops its request the cycle after line_resp. A request still high in the IDLE that follows DONE is treated as a new request.
- Beat counter: 2 bits, wraps 3→0 on the final beat, so it is 0 again in DONE.
- Reset mid-burst: next edge returns to IDLE with all outputs at reset values. The outstanding burst is abandoned and no line_resp is produced.

Optional Feature:
- Macro CACHELINE_ADAPTOR_PERF_EN.
- Defined:
  - rd_lines increments by 1 in each DONE that ends a READ; wr_lines likewise for WRITE.
  - Both are 32-bit counters that wrap at 2^32−1 → 0 and are cleared by reset.
- Undefined: rd_lines and wr_lines are tied to 0 and no counter flops are inferred.

Test Plan:
- Read, zero wait: line_read=1, line_addr=0x0000_1234, burst_rdata beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 with burst_resp every cycle.
  - Required: burst_addr=0x0000_1220.
  - Required: line_resp high exactly at cycle 5.
  - Required: line_rdata = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- Write with stalls: line_write=1, line_wdata = {D3,D2,D1,D0}, burst_resp delayed 2 idle cycles before each beat.
  - Required: burst_wdata shows D0, D1, D2, D3 in order and holds each beat until its strobe.
  - Required: burst_write is never low mid-burst.
  - Required: single line_resp.
- Simultaneous requests: line_read=line_write=1 in IDLE.
  - Required: the READ burst is issued first.
  - Required: after line_resp and DONE→IDLE, the WRITE burst is issued with the wdata sampled at its own acceptance.
- Back-to-back sequence: dcache-style dirty miss, write-back followed by a read fill on the next cycle after line_resp.
  - Required: two full bursts with exactly one IDLE cycle between them.
  - Required: two line_resp pulses.
- Reset mid-operation: rst=0 after the 2nd read beat.
  - Required: next cycle burst_read=0, line_resp never asserts, state IDLE.
  - Required: a fresh read after rst=1 completes normally.
- Perf, with CACHELINE_ADAPTOR_PERF_EN: 3 reads and 2 writes.
  - Required: rd_lines=3, wr_lines=2.
  - Required, without the macro: both remain 0.
